inverter_arbiter: RTL and testbench
===================================

INVERTER_ARBITER -- requirements
Module: inverter_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (fixed at 4; other values unsupported).
REQ-002 SHALL have parameter W, default 8, datapath width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-requester request; bit i set = requester i has a word pending.
REQ-006 SHALL have ports data0..data3  input  8 each  operand of requester i; stable while req[i] is high.
REQ-007 SHALL have port gnt  output  4  one-hot, one-cycle grant; data of that requester is sampled this cycle.
REQ-008 SHALL have port out_valid  output  1  out_data/out_id hold a valid result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-010 SHALL have port out_data  output  8  bitwise inverse of the granted operand.
REQ-011 SHALL have port out_id  output  2  index of the requester that produced out_data.
REQ-012 SHALL have port done_cnt  output  8  count of results accepted by the consumer.

Function
REQ-013 SHALL contain exactly one 8-bit inverter datapath, built from eight 1-bit inverter instances and shared by all requesters.
REQ-014 SHALL implement FSM states IDLE (no result held) and HOLD (result held, out_valid=1).
REQ-015 SHALL compute can_grant = (state==IDLE) or (state==HOLD and out_ready).
REQ-016 SHALL, when can_grant and req!=0, assert gnt for exactly one requester, chosen round-robin; gnt is combinational from registered state and req, and is 0 in all other cycles.
REQ-017 SHALL use a registered priority pointer ptr[1:0]; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); after a grant to i, ptr <= i+1 (mod 4).
REQ-018 SHALL, on the edge ending a grant cycle, load out_data <= ~data_i, out_id <= i, out_valid <= 1, state <= HOLD (latency: result valid 1 cycle after gnt).
REQ-019 SHALL, in HOLD with out_ready=1 and no grant, set out_valid <= 0 and state <= IDLE.
REQ-020 SHALL, in HOLD with out_ready=1 and a grant, replace the result in the same edge (back-to-back, 1 result/cycle); out_valid stays 1.
REQ-021 SHALL, in HOLD with out_ready=0, hold out_data, out_id, out_valid stable and assert no gnt.
REQ-022 SHALL increment done_cnt by 1 on each edge where out_valid and out_ready are both 1; wraps 255 -> 0.
REQ-023 SHALL ignore out_ready while out_valid=0 (no count, no state change).
REQ-024 SHALL treat a requester deasserting req before its gnt as withdrawal; no result is produced for it.
REQ-025 SHALL give requesters that keep req high no starvation: each is granted within 4 grants.

Reset
REQ-026 SHALL, on reset high at an edge, set state=IDLE, ptr=0, out_valid=0, out_data=8'h00, out_id=0, done_cnt=0, regardless of state or in-flight result (held result is discarded, not counted).
REQ-027 SHALL force gnt=0 during any cycle reset is high.
REQ-028 SHALL, in the first cycle after reset deasserts, grant with requester 0 highest priority.

Verification
REQ-029 Single: reset, req=0001, data0=8'hA5, out_ready=1 -> gnt=0001 that cycle; next cycle out_valid=1, out_data=8'h5A, out_id=0; done_cnt=1 after accept.
REQ-030 Round-robin: req=1111 held, data_i=8'h0i, out_ready=1 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; out_data 8'hFF,FE,FD,FC,FF.
REQ-031 Backpressure: result held with out_ready=0 for 5 cycles, req=0010 -> gnt=0 and out_data/out_id unchanged throughout; gnt=0010 in the cycle out_ready rises.
REQ-032 Wrap: 256 accepted results -> done_cnt returns to 8'h00; data 8'hFF -> out_data 8'h00, 8'h00 -> 8'hFF.
REQ-033 Reset mid-operation: out_valid=1, done_cnt=3, reset pulsed one cycle with out_ready=1 -> out_valid=0, done_cnt=0, gnt=0 during reset; next grant honours requester 0 first.
REQ-034 Withdrawal: req=0100 then 0000 while in HOLD with out_ready=0 -> no gnt to requester 2; after accept, state IDLE and out_valid=0.

Source files
------------

// File: rtl/inverter_arbiter.sv
// Round-robin arbiter that feeds four requesters through one shared
// inverter datapath and holds one registered result per grant.

module inv_bit (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module inverter_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    data0,
    input  logic [W-1:0]    data1,
    input  logic [W-1:0]    data2,
    input  logic [W-1:0]    data3,
    output logic [NREQ-1:0] gnt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [1:0]      out_id,
    output logic [7:0]      done_cnt
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   ptr;
    logic [1:0]   sel;
    logic [1:0]   idx;
    logic         found;
    logic         can_grant;
    logic         grant;
    logic [W-1:0] operand;
    logic [W-1:0] inv;

    assign out_valid = (state == HOLD);
    assign can_grant = (state == IDLE) || out_ready;

    // Search from ptr upward; the first pending requester wins.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (!reset && can_grant && found) begin
            gnt[sel] = 1'b1;
        end
    end

    assign grant = |gnt;

    always_comb begin
        operand = data0;
        unique case (sel)
            2'd0: operand = data0;
            2'd1: operand = data1;
            2'd2: operand = data2;
            2'd3: operand = data3;
        endcase
    end

    for (genvar b = 0; b < W; b++) begin : g_inv
        inv_bit u_inv (
            .a (operand[b]),
            .y (inv[b])
        );
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant) state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) state_nxt = grant ? HOLD : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            out_data <= '0;
            out_id   <= 2'd0;
            done_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                ptr      <= sel + 2'd1;
                out_data <= inv;
                out_id   <= sel;
            end
            if (out_valid && out_ready) begin
                done_cnt <= done_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_inverter_arbiter.sv
// Directed vector bench for inverter_arbiter: cycle table plus a
// long counter-wrap sequence.

module tb_inverter_arbiter;
    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [7:0] data0, data1, data2, data3;
    logic [3:0] gnt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic [7:0] done_cnt;

    int total = 0;
    int bad   = 0;

    inverter_arbiter #(.NREQ(4), .W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] d0, d1, d2, d3;
        logic       rdy;
        logic [3:0] g;
        logic       v;
        logic [7:0] od;
        logic [1:0] oid;
        logic [7:0] cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic rst, input logic [3:0] rq,
        input logic [7:0] a0, input logic [7:0] a1,
        input logic [7:0] a2, input logic [7:0] a3,
        input logic rdy, input logic [3:0] g, input logic v,
        input logic [7:0] od, input logic [1:0] oid,
        input logic [7:0] cnt);
        vec_t r;
        r.rst = rst; r.req = rq;
        r.d0 = a0; r.d1 = a1; r.d2 = a2; r.d3 = a3;
        r.rdy = rdy; r.g = g; r.v = v;
        r.od = od; r.oid = oid; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h expected=%h",
                     name, row, act, exp);
        end
    endtask

    task automatic check_row(input int n, input vec_t t);
        check("gnt", n, {4'h0, gnt}, {4'h0, t.g});
        check("out_valid", n, {7'h0, out_valid}, {7'h0, t.v});
        check("out_data", n, out_data, t.od);
        check("out_id", n, {6'h0, out_id}, {6'h0, t.oid});
        check("done_cnt", n, done_cnt, t.cnt);
    endtask

    initial begin
        reset = 1'b1; req = 4'h0; out_ready = 1'b0;
        data0 = 8'h00; data1 = 8'h00; data2 = 8'h00; data3 = 8'h00;

        // single request
        tv.push_back(mk(1, 4'b0001, 8'hA5, 0, 0, 0, 1, 4'b0000, 0, 8'h00, 0, 0));
        tv.push_back(mk(0, 4'b0001, 8'hA5, 0, 0, 0, 1, 4'b0001, 0, 8'h00, 0, 0));
        tv.push_back(mk(0, 4'b0000, 8'hA5, 0, 0, 0, 1, 4'b0000, 1, 8'h5A, 0, 0));
        tv.push_back(mk(0, 4'b0000, 8'hA5, 0, 0, 0, 1, 4'b0000, 0, 8'h5A, 0, 1));
        // round robin after reset
        tv.push_back(mk(1, 4'b1111, 0, 1, 2, 3, 1, 4'b0000, 0, 8'h5A, 0, 1));
        tv.push_back(mk(0, 4'b1111, 0, 1, 2, 3, 1, 4'b0001, 0, 8'h00, 0, 0));
        tv.push_back(mk(0, 4'b1111, 0, 1, 2, 3, 1, 4'b0010, 1, 8'hFF, 0, 0));
        tv.push_back(mk(0, 4'b1111, 0, 1, 2, 3, 1, 4'b0100, 1, 8'hFE, 1, 1));
        tv.push_back(mk(0, 4'b1111, 0, 1, 2, 3, 1, 4'b1000, 1, 8'hFD, 2, 2));
        tv.push_back(mk(0, 4'b1111, 0, 1, 2, 3, 1, 4'b0001, 1, 8'hFC, 3, 3));
        tv.push_back(mk(0, 4'b0000, 0, 1, 2, 3, 1, 4'b0000, 1, 8'hFF, 0, 4));
        tv.push_back(mk(0, 4'b0000, 0, 1, 2, 3, 1, 4'b0000, 0, 8'hFF, 0, 5));
        // backpressure
        tv.push_back(mk(0, 4'b0001, 8'h33, 8'h44, 0, 0, 0, 4'b0001, 0, 8'hFF, 0, 5));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(0, 4'b0010, 8'h33, 8'h44, 0, 0, 0, 4'b0000, 1, 8'hCC, 0, 5));
        tv.push_back(mk(0, 4'b0010, 8'h33, 8'h44, 0, 0, 1, 4'b0010, 1, 8'hCC, 0, 5));
        tv.push_back(mk(0, 4'b0000, 8'h33, 8'h44, 0, 0, 0, 4'b0000, 1, 8'hBB, 1, 6));
        // withdrawal while held
        tv.push_back(mk(0, 4'b0100, 0, 0, 8'h55, 0, 0, 4'b0000, 1, 8'hBB, 1, 6));
        tv.push_back(mk(0, 4'b0000, 0, 0, 8'h55, 0, 0, 4'b0000, 1, 8'hBB, 1, 6));
        tv.push_back(mk(0, 4'b0000, 0, 0, 8'h55, 0, 1, 4'b0000, 1, 8'hBB, 1, 6));
        tv.push_back(mk(0, 4'b0000, 0, 0, 8'h55, 0, 1, 4'b0000, 0, 8'hBB, 1, 7));
        tv.push_back(mk(0, 4'b0000, 0, 0, 8'h55, 0, 1, 4'b0000, 0, 8'hBB, 1, 7));
        // all-ones / all-zeros operands
        tv.push_back(mk(0, 4'b1000, 0, 0, 0, 8'hFF, 1, 4'b1000, 0, 8'hBB, 1, 7));
        tv.push_back(mk(0, 4'b0001, 0, 0, 0, 8'hFF, 1, 4'b0001, 1, 8'h00, 3, 7));
        tv.push_back(mk(0, 4'b0000, 0, 0, 0, 8'hFF, 1, 4'b0000, 1, 8'hFF, 0, 8));
        // reset while a result is held
        tv.push_back(mk(0, 4'b0001, 8'h11, 0, 0, 0, 0, 4'b0001, 0, 8'hFF, 0, 9));
        tv.push_back(mk(1, 4'b0010, 8'h11, 0, 0, 0, 1, 4'b0000, 1, 8'hEE, 0, 9));
        tv.push_back(mk(0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1, 4'b0001, 0, 8'h00, 0, 0));
        tv.push_back(mk(0, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 1, 4'b0000, 1, 8'hEE, 0, 0));

        foreach (tv[n]) begin
            @(negedge clk);
            reset = tv[n].rst; req = tv[n].req; out_ready = tv[n].rdy;
            data0 = tv[n].d0; data1 = tv[n].d1;
            data2 = tv[n].d2; data3 = tv[n].d3;
            #1;
            check_row(n, tv[n]);
        end

        // counter wrap: 256 back-to-back results from requester 0
        @(negedge clk);
        reset = 1'b1; req = 4'h0; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            reset = 1'b0; req = 4'b0001; data0 = 8'(i);
            #1;
            if (i == 0 || i == 128 || i == 255)
                check("wrap_gnt", i, {4'h0, gnt}, 8'h01);
            if (i == 128 || i == 255)
                check("wrap_cnt", i, done_cnt, 8'(i - 1));
        end
        @(negedge clk);
        req = 4'h0;
        #1;
        check("wrap_cnt_255", 256, done_cnt, 8'hFF);
        check("wrap_data_ff", 256, out_data, 8'h00);
        @(negedge clk);
        #1;
        check("wrap_cnt_0", 257, done_cnt, 8'h00);
        check("wrap_valid", 257, {7'h0, out_valid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
